// File: rtl/fp_addsub_param.sv
// Parametrised IEEE-754 adder/subtractor with strobe/ack handshakes on both sides.
// Runs as a multi-cycle FSM and reports invalid/overflow/inexact with each result.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_op,
    input  logic                 in_stb,
    output logic                 in_ack,
    output logic [EXP_W+MAN_W:0] out_z,
    output logic                 out_stb,
    input  logic                 out_ack,
    output logic                 out_invalid,
    output logic                 out_overflow,
    output logic                 out_inexact
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    typedef logic signed [EXP_W+1:0] exp_t;
    typedef logic [MAN_W+3:0] man_t;   // hidden, fraction, guard, round, sticky
    typedef logic [MAN_W+4:0] acc_t;   // man_t plus a carry-out bit
    typedef logic [W-1:0] word_t;
    typedef enum logic [3:0] {
        GET, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, PUT
    } state_t;

    localparam exp_t  BIAS_E = exp_t'(BIAS);
    localparam exp_t  E_MIN  = exp_t'(1 - BIAS);
    localparam exp_t  E_INF  = exp_t'((1 << EXP_W) - 1);
    localparam word_t QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_t state_q, state_d;
    logic   in_ack_q, in_ack_d, out_stb_q, out_stb_d;
    word_t  out_z_q, out_z_d;
    logic   inv_q, inv_d, ovf_q, ovf_d, inx_q, inx_d;
    word_t  a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic   a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    exp_t   a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    man_t   a_m_q, a_m_d, b_m_q, b_m_d;
    acc_t   z_m_q, z_m_d;

    // Right shift that folds every bit shifted out into the sticky position.
    function automatic man_t shr_sticky(input man_t m, input logic [EXP_W+1:0] sh);
        man_t mask;
        man_t res;
        if (int'(sh) >= MAN_W + 4) begin
            res = {{(MAN_W+3){1'b0}}, |m};
        end else begin
            mask   = ~({(MAN_W+4){1'b1}} << sh);
            res    = m >> sh;
            res[0] = res[0] | (|(m & mask));
        end
        return res;
    endfunction

    logic a_e_max, b_e_max, a_e_zero, b_e_zero, a_f_zero, b_f_zero;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a_e_max  = &a_raw_q[W-2:MAN_W];
    assign b_e_max  = &b_raw_q[W-2:MAN_W];
    assign a_e_zero = ~|a_raw_q[W-2:MAN_W];
    assign b_e_zero = ~|b_raw_q[W-2:MAN_W];
    assign a_f_zero = ~|a_raw_q[MAN_W-1:0];
    assign b_f_zero = ~|b_raw_q[MAN_W-1:0];
    assign a_nan    = a_e_max & ~a_f_zero;
    assign b_nan    = b_e_max & ~b_f_zero;
    assign a_inf    = a_e_max & a_f_zero;
    assign b_inf    = b_e_max & b_f_zero;
    assign a_zero   = a_e_zero & a_f_zero;
    assign b_zero   = b_e_zero & b_f_zero;

    exp_t             ediff;
    logic [EXP_W+1:0] shamt;
    logic             rnd_up;
    logic [MAN_W+1:0] rnd_sum;
    exp_t             pack_e;

    assign ediff   = a_e_q - b_e_q;
    assign shamt   = ediff[EXP_W+1] ? -ediff : ediff;
    // Nearest-even: round up above half, or at exactly half when the LSB is odd.
    assign rnd_up  = z_m_q[2] & (z_m_q[1] | z_m_q[0] | z_m_q[3]);
    assign rnd_sum = {1'b0, z_m_q[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    assign pack_e  = z_e_q + BIAS_E;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path can infer a latch.
        state_d   = state_q;
        in_ack_d  = in_ack_q;
        out_stb_d = out_stb_q;
        out_z_d   = out_z_q;
        inv_d     = inv_q;
        ovf_d     = ovf_q;
        inx_d     = inx_q;
        a_raw_d   = a_raw_q;
        b_raw_d   = b_raw_q;
        a_s_d     = a_s_q;
        b_s_d     = b_s_q;
        z_s_d     = z_s_q;
        a_e_d     = a_e_q;
        b_e_d     = b_e_q;
        z_e_d     = z_e_q;
        a_m_d     = a_m_q;
        b_m_d     = b_m_q;
        z_m_d     = z_m_q;

        unique case (state_q)
            GET: begin
                in_ack_d = 1'b1;
                if (in_ack_q && in_stb) begin
                    a_raw_d  = in_a;
                    b_raw_d  = {in_b[W-1] ^ in_op, in_b[W-2:0]};
                    in_ack_d = 1'b0;
                    inv_d    = 1'b0;
                    ovf_d    = 1'b0;
                    inx_d    = 1'b0;
                    state_d  = UNPACK;
                end
            end
            UNPACK: begin
                a_s_d   = a_raw_q[W-1];
                b_s_d   = b_raw_q[W-1];
                a_e_d   = exp_t'({2'b00, a_raw_q[W-2:MAN_W]}) - BIAS_E;
                b_e_d   = exp_t'({2'b00, b_raw_q[W-2:MAN_W]}) - BIAS_E;
                a_m_d   = {1'b0, a_raw_q[MAN_W-1:0], 3'b000};
                b_m_d   = {1'b0, b_raw_q[MAN_W-1:0], 3'b000};
                state_d = SPECIAL;
            end
            SPECIAL: begin
                state_d = PUT;
                if (a_nan || b_nan || (a_inf && b_inf && (a_s_q != b_s_q))) begin
                    out_z_d = QNAN;
                    inv_d   = 1'b1;
                end else if (a_inf) begin
                    out_z_d = a_raw_q;
                end else if (b_inf) begin
                    out_z_d = b_raw_q;
                end else if (a_zero && b_zero) begin
                    out_z_d = {a_s_q & b_s_q, {(W-1){1'b0}}};
                end else if (a_zero) begin
                    out_z_d = b_raw_q;
                end else if (b_zero) begin
                    out_z_d = a_raw_q;
                end else begin
                    if (a_e_zero) a_e_d = E_MIN;
                    else          a_m_d[MAN_W+3] = 1'b1;
                    if (b_e_zero) b_e_d = E_MIN;
                    else          b_m_d[MAN_W+3] = 1'b1;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (!ediff[EXP_W+1]) begin
                    b_m_d = shr_sticky(b_m_q, shamt);
                    z_e_d = a_e_q;
                end else begin
                    a_m_d = shr_sticky(a_m_q, shamt);
                    z_e_d = b_e_q;
                end
                state_d = ADD;
            end
            ADD: begin
                state_d = NORM;
                if (a_s_q == b_s_q) begin
                    z_m_d = {1'b0, a_m_q} + {1'b0, b_m_q};
                    z_s_d = a_s_q;
                end else if (a_m_q == b_m_q) begin
                    z_m_d   = '0;
                    z_s_d   = 1'b0;
                    state_d = PACK;
                end else if (a_m_q > b_m_q) begin
                    z_m_d = {1'b0, a_m_q - b_m_q};
                    z_s_d = a_s_q;
                end else begin
                    z_m_d = {1'b0, b_m_q - a_m_q};
                    z_s_d = b_s_q;
                end
            end
            NORM: begin
                if (z_m_q[MAN_W+4]) begin
                    z_m_d   = {1'b0, z_m_q[MAN_W+4:2], z_m_q[1] | z_m_q[0]};
                    z_e_d   = z_e_q + exp_t'(1);
                    state_d = ROUND;
                end else if (z_e_q < E_MIN) begin
                    z_m_d = {1'b0, z_m_q[MAN_W+4:2], z_m_q[1] | z_m_q[0]};
                    z_e_d = z_e_q + exp_t'(1);
                end else if (!z_m_q[MAN_W+3] && (z_e_q > E_MIN)) begin
                    // Sticky stays put; the round bit takes a zero.
                    z_m_d = {z_m_q[MAN_W+3:2], z_m_q[1], 1'b0, z_m_q[0]};
                    z_e_d = z_e_q - exp_t'(1);
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                inx_d = |z_m_q[2:0];
                if (rnd_sum[MAN_W+1]) begin
                    z_m_d = {2'b01, {MAN_W{1'b0}}, 3'b000};
                    z_e_d = z_e_q + exp_t'(1);
                end else begin
                    z_m_d = {1'b0, rnd_sum[MAN_W:0], 3'b000};
                end
                state_d = PACK;
            end
            PACK: begin
                if (pack_e >= E_INF) begin
                    out_z_d = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d   = 1'b1;
                    inx_d   = 1'b1;
                end else if (!z_m_q[MAN_W+3]) begin
                    out_z_d = {z_s_q, {EXP_W{1'b0}}, z_m_q[MAN_W+2:3]};
                end else begin
                    out_z_d = {z_s_q, pack_e[EXP_W-1:0], z_m_q[MAN_W+2:3]};
                end
                state_d = PUT;
            end
            PUT: begin
                out_stb_d = 1'b1;
                if (out_stb_q && out_ack) begin
                    out_stb_d = 1'b0;
                    state_d   = GET;
                end
            end
            default: state_d = GET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= GET;
            in_ack_q  <= 1'b0;
            out_stb_q <= 1'b0;
            out_z_q   <= '0;
            inv_q     <= 1'b0;
            ovf_q     <= 1'b0;
            inx_q     <= 1'b0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            a_s_q     <= 1'b0;
            b_s_q     <= 1'b0;
            z_s_q     <= 1'b0;
            a_e_q     <= '0;
            b_e_q     <= '0;
            z_e_q     <= '0;
            a_m_q     <= '0;
            b_m_q     <= '0;
            z_m_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            in_ack_q  <= in_ack_d;
            out_stb_q <= out_stb_d;
            out_z_q   <= out_z_d;
            inv_q     <= inv_d;
            ovf_q     <= ovf_d;
            inx_q     <= inx_d;
            a_raw_q   <= a_raw_d;
            b_raw_q   <= b_raw_d;
            a_s_q     <= a_s_d;
            b_s_q     <= b_s_d;
            z_s_q     <= z_s_d;
            a_e_q     <= a_e_d;
            b_e_q     <= b_e_d;
            z_e_q     <= z_e_d;
            a_m_q     <= a_m_d;
            b_m_q     <= b_m_d;
            z_m_q     <= z_m_d;
        end
    end

    assign in_ack       = in_ack_q;
    assign out_stb      = out_stb_q;
    assign out_z        = out_z_q;
    assign out_invalid  = inv_q;
    assign out_overflow = ovf_q;
    assign out_inexact  = inx_q;
endmodule
